fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the in-order RV32 pipeline. It supports N read ports, a configurable number of post-EX forwarding stages and per-instruction result latency. It keeps an internal shadow pipeline of in-flight destination tags and forwards from the youngest matching producer. When that producer's data is not yet available (load-use or multi-cycle result), it asserts a stall and inserts a bubble. Sits beside the ID/EX register and drives the EX operand muxes and the ID/EX hold logic.

---
 rtl/fwd_hazard_unit.sv | 90 +++++++++
 tb/tb_fwd_hazard_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: shadow pipeline of in-flight destination tags,
// youngest-producer operand forwarding and load-use / multi-cycle stall.
module fwd_hazard_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_STAGES     = 3,
   parameter int NUM_PORTS      = 2,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              adv,
   input  logic                              flush,
   input  logic                              ex_valid,
   input  logic                              ex_we,
   input  logic [REG_ADDR_WIDTH-1:0]         ex_rd,
   input  logic [1:0]                        ex_lat,
   input  logic [NUM_PORTS*REG_ADDR_WIDTH-1:0] ex_rs,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   ex_rs_data,
   input  logic [NUM_STAGES*DATA_WIDTH-1:0]  stage_data,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]   fwd_data,
   output logic                              stall,
   output logic [CNT_WIDTH-1:0]              stall_cnt
);

   localparam int DW   = DATA_WIDTH;
   localparam int RAW  = REG_ADDR_WIDTH;
   localparam int NS   = NUM_STAGES;
   localparam int NP   = NUM_PORTS;
   localparam int LAST = NS - 1;

   typedef struct packed {
      logic           vld;
      logic [RAW-1:0] rd;
      logic [1:0]     rdy;
   } ent_t;

   ent_t                   r_ent [NS];
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic [NP*DW-1:0]       w_fwd;
   logic [NP-1:0]          w_haz;
   logic [RAW-1:0]         w_rs;
   logic                   w_hit;
   logic                   w_stall;
   logic                   w_push;
   logic [1:0]             w_rdy_new;

   // Lowest stage index is the youngest producer, so the first hit wins.
   always_comb begin
      w_fwd = ex_rs_data;
      w_haz = '0;
      w_rs  = '0;
      w_hit = 1'b0;
      for (int p = 0; p < NP; p++) begin
         w_rs  = ex_rs[p*RAW +: RAW];
         w_hit = 1'b0;
         if (w_rs != '0) begin
            for (int s = 0; s < NS; s++) begin
               if (!w_hit && r_ent[s].vld && r_ent[s].rd == w_rs) begin
                  w_hit = 1'b1;
                  w_fwd[p*DW +: DW] = stage_data[s*DW +: DW];
                  w_haz[p] = (s < int'(r_ent[s].rdy));
               end
            end
         end
      end
   end

   assign w_stall   = ex_valid && !flush && (|w_haz);
   assign w_push    = ex_valid && !flush && !w_stall;
   assign w_rdy_new = (int'(ex_lat) > LAST) ? 2'(LAST) : ex_lat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NS; s++) r_ent[s] <= '0;
         r_cnt <= '0;
      end else if (adv) begin
         for (int s = NS - 1; s > 0; s--) r_ent[s] <= r_ent[s-1];
         r_ent[0].vld <= w_push && ex_we && (ex_rd != '0);
         r_ent[0].rd  <= ex_rd;
         r_ent[0].rdy <= w_rdy_new;
         if (w_stall && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign fwd_data  = w_fwd;
   assign stall     = w_stall;
   assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomised and directed bench for fwd_hazard_unit with a timestamp-based
// reference model and a scoreboard drained by a negedge monitor.
module tb_fwd_hazard_unit;

   localparam int DW = 32;
   localparam int RAW = 5;
   localparam int NS = 3;
   localparam int NP = 2;
   localparam int CW = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              adv, flush, ex_valid, ex_we;
   logic [RAW-1:0]    ex_rd;
   logic [1:0]        ex_lat;
   logic [NP*RAW-1:0] ex_rs;
   logic [NP*DW-1:0]  ex_rs_data;
   logic [NS*DW-1:0]  stage_data;
   logic [NP*DW-1:0]  fwd_data;
   logic              stall;
   logic [CW-1:0]     stall_cnt;

   fwd_hazard_unit #(
      .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .NUM_STAGES(NS),
      .NUM_PORTS(NP), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .adv(adv), .flush(flush),
      .ex_valid(ex_valid), .ex_we(ex_we), .ex_rd(ex_rd), .ex_lat(ex_lat),
      .ex_rs(ex_rs), .ex_rs_data(ex_rs_data), .stage_data(stage_data),
      .fwd_data(fwd_data), .stall(stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [RAW-1:0] rd;
      int             lat;
      int             tpush;
   } prod_t;

   typedef struct {
      logic [NP*DW-1:0] fwd;
      logic             st;
      logic [CW-1:0]    cnt;
   } exp_t;

   prod_t prods[$];
   exp_t  sb[$];
   int    nadv = 0;
   int    m_cnt = 0;
   int    n_chk = 0;
   int    n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   // A producer pushed when nadv was t sits in stage nadv-t-1.
   function automatic exp_t model_eval();
      exp_t e;
      logic haz;
      haz = 1'b0;
      e.fwd = ex_rs_data;
      for (int p = 0; p < NP; p++) begin
         logic [RAW-1:0] rs;
         int best;
         rs = ex_rs[p*RAW +: RAW];
         best = -1;
         if (rs != 0) begin
            foreach (prods[i]) begin
               int s;
               s = nadv - prods[i].tpush - 1;
               if (s < NS && prods[i].rd == rs)
                  if (best < 0 || prods[i].tpush > prods[best].tpush)
                     best = i;
            end
         end
         if (best >= 0) begin
            int s, need;
            s = nadv - prods[best].tpush - 1;
            need = (prods[best].lat > NS - 1) ? NS - 1 : prods[best].lat;
            e.fwd[p*DW +: DW] = stage_data[s*DW +: DW];
            if (s < need) haz = 1'b1;
         end
      end
      e.st = ex_valid && !flush && haz;
      e.cnt = CW'(m_cnt);
      return e;
   endfunction

   task automatic cycle();
      exp_t e;
      e = model_eval();
      sb.push_back(e);
      @(posedge clk);
      if (adv) begin
         if (!e.st && !flush && ex_valid && ex_we && ex_rd != 0) begin
            prod_t pr;
            pr.rd = ex_rd;
            pr.lat = int'(ex_lat);
            pr.tpush = nadv;
            prods.push_back(pr);
         end
         if (e.st && m_cnt != (1 << CW) - 1) m_cnt++;
         nadv++;
         while (prods.size() > 0 && nadv - prods[0].tpush - 1 >= NS)
            void'(prods.pop_front());
      end
      #1;
   endtask

   task automatic drv(input logic a, f, v, w, input logic [RAW-1:0] rd,
                      input logic [1:0] lat, input logic [RAW-1:0] rs0, rs1,
                      input logic [DW-1:0] r0, r1, s0, s1, s2);
      adv = a; flush = f; ex_valid = v; ex_we = w;
      ex_rd = rd; ex_lat = lat;
      ex_rs = {rs1, rs0};
      ex_rs_data = {r1, r0};
      stage_data = {s2, s1, s0};
   endtask

   task automatic push(input logic [RAW-1:0] rd, input logic [1:0] lat);
      drv(1, 0, 1, 1, rd, lat, 0, 0, $urandom, $urandom, 0, 0, 0);
      cycle();
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("fwd_data", 64'(fwd_data), 64'(e.fwd));
         chk("stall", 64'(stall), 64'(e.st));
         chk("stall_cnt", 64'(stall_cnt), 64'(e.cnt));
      end
   end

   initial begin
      exp_t e;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #12 rst_n = 1'b1;
      @(posedge clk); #1;

      drv(1, 0, 0, 0, 0, 0, 3, 4, 32'h100, 32'h200, 1, 2, 3);
      cycle();

      push(5, 0);
      drv(1, 0, 1, 0, 0, 0, 5, 0, 32'hdead, 32'hbeef, 32'h11, 32'h99, 32'h98);
      cycle();

      push(7, 1);
      drv(1, 0, 1, 0, 0, 0, 0, 7, 1, 2, 32'hAA, 32'h55, 0);
      cycle();
      drv(1, 0, 1, 0, 0, 0, 0, 7, 1, 2, 32'hAA, 32'hAB, 0);
      cycle();

      push(3, 0);
      push(4, 0);
      push(3, 0);
      drv(1, 0, 1, 0, 0, 0, 3, 3, 5, 6, 32'h22, 32'h44, 32'h33);
      cycle();

      push(0, 0);
      drv(1, 0, 1, 0, 0, 0, 0, 9, 0, 32'h1234, 32'h7, 32'h8, 32'h9);
      cycle();

      push(7, 3);
      for (int i = 0; i < 3; i++) begin
         drv(0, 0, 1, 0, 0, 0, 7, 0, 1, 2, 32'hC0, 32'hC1, 32'hC2);
         cycle();
      end
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, 1, 0, 0, 0, 7, 0, 1, 2, 32'hC0, 32'hC1, 32'hC2);
         cycle();
      end

      push(7, 1);
      drv(1, 1, 1, 1, 12, 0, 7, 0, 1, 2, 32'hD0, 32'hD1, 32'hD2);
      cycle();
      drv(1, 0, 1, 0, 0, 0, 12, 7, 32'hE0, 32'hE1, 32'hD0, 32'hD1, 32'hD2);
      cycle();

      for (int i = 0; i < 400; i++) begin
         drv(($urandom % 8) != 0, ($urandom % 10) == 0, ($urandom % 6) != 0,
             ($urandom % 4) != 0, RAW'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), RAW'($urandom_range(0, 7)),
             RAW'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, $urandom, $urandom);
         cycle();
      end

      push(7, 1);
      drv(1, 0, 1, 0, 0, 0, 0, 7, 32'h77, 32'h88, 32'hF0, 32'hF1, 32'hF2);
      e = model_eval();
      #1;
      chk("pre_reset_stall", 64'(stall), 64'(e.st));
      chk("pre_reset_stall_req", 64'(stall), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_fwd", 64'(fwd_data), 64'(ex_rs_data));
      prods.delete();
      m_cnt = 0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 20; i++) begin
         drv(1, 0, 1, 1, RAW'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             RAW'($urandom_range(0, 7)), RAW'($urandom_range(0, 7)),
             $urandom, $urandom, $urandom, $urandom, $urandom);
         cycle();
      end

      @(negedge clk); #1;
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
